// File: rtl/accel_pair_scheduler.sv
// Pair sequencer feeding getAccl: streams every (i, j != i) body pair and carries a
// LATENCY-deep tag pipe so the accumulator knows which target/first/last each result is.
module accel_pair_scheduler #(
  parameter int IDX_W   = 10,
  parameter int LATENCY = 122
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] num_bodies,
  output logic             busy,
  output logic             done,
  output logic             mem_rd,
  output logic [IDX_W-1:0] mem_addr,
  input  logic [63:0]      mem_x,
  input  logic [63:0]      mem_y,
  input  logic [63:0]      mem_m,
  output logic [63:0]      x1,
  output logic [63:0]      y1,
  output logic [63:0]      x2,
  output logic [63:0]      y2,
  output logic [63:0]      m2,
  output logic             issue_valid,
  output logic             acc_valid,
  output logic [IDX_W-1:0] acc_idx,
  output logic             acc_first,
  output logic             acc_last
);

  typedef enum logic [2:0] {IDLE, LOAD_I, LATCH_I, STREAM, DRAIN, DONE} state_t;

  localparam int TAG_W = IDX_W + 3;
  localparam int CNT_W = $clog2(LATENCY + 2);
  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);
  localparam logic [IDX_W-1:0] TWO = IDX_W'(2);

  state_t           state;
  logic [IDX_W-1:0] n;
  logic [IDX_W-1:0] i;
  logic             first_pend;
  logic             rd_d;
  logic             first_d;
  logic             last_d;
  logic [IDX_W-1:0] idx_d;
  logic [IDX_W-1:0] issue_idx;
  logic             issue_first;
  logic             issue_last;
  logic [CNT_W-1:0] cnt;
  logic [TAG_W-1:0] tag_pipe [LATENCY];

  logic             i_last;
  logic [IDX_W-1:0] j_last;
  logic [IDX_W-1:0] j_next;
  logic             at_last;

  // During STREAM mem_addr doubles as the source index j.
  always_comb begin
    i_last  = (i == n - ONE);
    j_last  = i_last ? n - TWO : n - ONE;
    j_next  = (mem_addr + ONE == i) ? mem_addr + TWO : mem_addr + ONE;
    at_last = (mem_addr == j_last);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      n           <= '0;
      i           <= '0;
      first_pend  <= 1'b0;
      rd_d        <= 1'b0;
      first_d     <= 1'b0;
      last_d      <= 1'b0;
      idx_d       <= '0;
      issue_idx   <= '0;
      issue_first <= 1'b0;
      issue_last  <= 1'b0;
      issue_valid <= 1'b0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      x1          <= '0;
      y1          <= '0;
      x2          <= '0;
      y2          <= '0;
      m2          <= '0;
      for (int k = 0; k < LATENCY; k++) tag_pipe[k] <= '0;
    end else begin
      // Read data for a STREAM cycle arrives one cycle later; its tag travels alongside.
      rd_d    <= (state == STREAM);
      first_d <= first_pend;
      last_d  <= at_last;
      idx_d   <= i;

      issue_valid <= rd_d;
      if (rd_d) begin
        x2          <= mem_x;
        y2          <= mem_y;
        m2          <= mem_m;
        issue_idx   <= idx_d;
        issue_first <= first_d;
        issue_last  <= last_d;
      end

      tag_pipe[0] <= {issue_valid, issue_idx, issue_first, issue_last};
      for (int k = 1; k < LATENCY; k++) tag_pipe[k] <= tag_pipe[k-1];

      case (state)
        IDLE: begin
          if (start) begin
            n    <= num_bodies;
            i    <= '0;
            busy <= 1'b1;
            if (num_bodies >= TWO) begin
              state    <= LOAD_I;
              mem_rd   <= 1'b1;
              mem_addr <= '0;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        LOAD_I: begin
          mem_rd <= 1'b0;
          state  <= LATCH_I;
        end
        LATCH_I: begin
          x1         <= mem_x;
          y1         <= mem_y;
          mem_rd     <= 1'b1;
          mem_addr   <= (i == '0) ? ONE : '0;
          first_pend <= 1'b1;
          state      <= STREAM;
        end
        STREAM: begin
          first_pend <= 1'b0;
          if (at_last) begin
            if (!i_last) begin
              i        <= i + ONE;
              mem_addr <= i + ONE;
              state    <= LOAD_I;
            end else begin
              mem_rd <= 1'b0;
              cnt    <= '0;
              state  <= DRAIN;
            end
          end else begin
            mem_addr <= j_next;
          end
        end
        // The last read needs two cycles to issue plus LATENCY to emerge from the tag pipe.
        DRAIN: begin
          if (cnt == CNT_W'(LATENCY + 1)) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign {acc_valid, acc_idx, acc_first, acc_last} = tag_pipe[LATENCY-1];

endmodule

// File: tb/tb_accel_pair_scheduler.sv
// Scoreboard bench for accel_pair_scheduler: expected pairs are queued at start,
// popped on issue_valid, and re-queued as tags expected LATENCY cycles later.
module tb_accel_pair_scheduler;
  localparam int IDX_W   = 10;
  localparam int LATENCY = 122;

  logic             clk;
  logic             rst;
  logic             start;
  logic [IDX_W-1:0] num_bodies;
  logic             busy, done, mem_rd;
  logic [IDX_W-1:0] mem_addr;
  logic [63:0]      mem_x, mem_y, mem_m;
  logic [63:0]      x1, y1, x2, y2, m2;
  logic             issue_valid, acc_valid, acc_first, acc_last;
  logic [IDX_W-1:0] acc_idx;

  accel_pair_scheduler #(.IDX_W(IDX_W), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .start(start), .num_bodies(num_bodies),
    .busy(busy), .done(done), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_x(mem_x), .mem_y(mem_y), .mem_m(mem_m),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .m2(m2),
    .issue_valid(issue_valid), .acc_valid(acc_valid), .acc_idx(acc_idx),
    .acc_first(acc_first), .acc_last(acc_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] ram_x [16];
  logic [63:0] ram_y [16];
  logic [63:0] ram_m [16];

  always @(posedge clk) begin
    if (mem_rd) begin
      mem_x <= ram_x[mem_addr[3:0]];
      mem_y <= ram_y[mem_addr[3:0]];
      mem_m <= ram_m[mem_addr[3:0]];
    end
  end

  typedef struct {int i; int j; logic first; logic last;} pair_t;
  typedef struct {longint cyc; int i; logic first; logic last;} tag_t;

  pair_t  issueQ[$];
  tag_t   accQ[$];
  pair_t  p;
  tag_t   t;
  int     checksRun = 0;
  int     checksPassed = 0;
  longint cycle = 0;
  longint expDoneCycle = -1;
  int     issueCount, accCount, doneCount, memReadCount;
  logic   shortPass = 1'b0;
  logic   donePrev = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checksRun++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", tag, actual, expected, cycle);
  endtask

  // Monitor: compares every issue and every accumulator tag against the queues.
  always @(negedge clk) begin
    cycle++;
    if (!rst) begin
      if (mem_rd) memReadCount++;
      if (start && !busy && shortPass) expDoneCycle = cycle + 1;
      if (issue_valid) begin
        issueCount++;
        if (issueQ.size() == 0) checkOutput("issue_unexpected", 1, 0);
        else begin
          p = issueQ.pop_front();
          checkOutput("x1", x1, ram_x[p.i]);
          checkOutput("y1", y1, ram_y[p.i]);
          checkOutput("x2", x2, ram_x[p.j]);
          checkOutput("y2", y2, ram_y[p.j]);
          checkOutput("m2", m2, ram_m[p.j]);
          accQ.push_back('{cycle + LATENCY, p.i, p.first, p.last});
        end
      end
      if (acc_valid) begin
        accCount++;
        if (accQ.size() == 0) checkOutput("acc_unexpected", 1, 0);
        else begin
          t = accQ.pop_front();
          checkOutput("acc_cycle", cycle, t.cyc);
          checkOutput("acc_idx", acc_idx, t.i);
          checkOutput("acc_first", acc_first, t.first);
          checkOutput("acc_last", acc_last, t.last);
          if (accQ.size() == 0 && issueQ.size() == 0) expDoneCycle = cycle + 1;
        end
      end
      if (done) begin
        doneCount++;
        checkOutput("done_cycle", cycle, expDoneCycle);
        checkOutput("busy_at_done", busy, 1);
      end
      if (donePrev) checkOutput("busy_after_done", busy, 0);
      donePrev = done;
    end else begin
      donePrev = 1'b0;
    end
  end

  task automatic clearCounts();
    issueCount = 0; accCount = 0; doneCount = 0; memReadCount = 0;
    expDoneCycle = -1;
  endtask

  task automatic pushExpected(input int n);
    int js[$];
    for (int i = 0; i < n; i++) begin
      js.delete();
      for (int j = 0; j < n; j++) if (j != i) js.push_back(j);
      foreach (js[k]) issueQ.push_back('{i, js[k], k == 0, k == js.size() - 1});
    end
  endtask

  task automatic waitDone(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (doneCount != 0) break;
    end
    checkOutput("done_seen", doneCount != 0, 1);
  endtask

  task automatic launch(input int n);
    clearCounts();
    shortPass = (n < 2);
    pushExpected(n);
    @(posedge clk); #1;
    num_bodies = IDX_W'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    num_bodies = IDX_W'(7);
  endtask

  task automatic applyStimulus(input int n, input int extraStartAt);
    launch(n);
    if (extraStartAt >= 0) begin
      repeat (extraStartAt) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    waitDone(2000);
    repeat (4) @(negedge clk);
    #1;
    checkOutput("issue_count", issueCount, n * (n - 1));
    checkOutput("acc_count", accCount, n * (n - 1));
    checkOutput("done_count", doneCount, 1);
    if (n < 2) checkOutput("mem_rd_count", memReadCount, 0);
    checkOutput("queues_empty", issueQ.size() + accQ.size(), 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctrl"}, {busy, done, mem_rd, issue_valid, acc_valid, acc_first, acc_last}, 0);
    checkOutput({tag, "_idx"}, {mem_addr, acc_idx}, 0);
    checkOutput({tag, "_data"}, x1 | y1 | x2 | y2 | m2, 0);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      ram_x[k] = $realtobits(1.5 * k);
      ram_y[k] = $realtobits(-2.0 * k);
      ram_m[k] = $realtobits(real'(k + 1));
    end
    ram_x[0] = $realtobits(0.0);  ram_y[0] = $realtobits(0.0);  ram_m[0] = $realtobits(1.0);
    ram_x[1] = $realtobits(10.0); ram_y[1] = $realtobits(0.0);  ram_m[1] = $realtobits(2.0);
    ram_x[2] = $realtobits(0.0);  ram_y[2] = $realtobits(20.0); ram_m[2] = $realtobits(3.0);

    rst = 1'b1; start = 1'b0; num_bodies = '0;
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    checkAllZero("reset");
    @(posedge clk); #1 rst = 1'b0;

    $display("[TB] N=3 reference pass");
    applyStimulus(3, -1);
    $display("[TB] N=1 and N=0 short passes");
    applyStimulus(1, -1);
    applyStimulus(0, -1);
    $display("[TB] N=4 with ignored second start");
    applyStimulus(4, 20);

    $display("[TB] N=8 aborted by reset during STREAM");
    launch(8);
    repeat (24) @(posedge clk);
    #1 rst = 1'b1;
    issueQ.delete();
    accQ.delete();
    clearCounts();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    checkAllZero("midrst");
    repeat (200) @(negedge clk);
    #1;
    checkOutput("post_rst_acc", accCount, 0);
    checkOutput("post_rst_issue", issueCount, 0);
    checkOutput("post_rst_done", doneCount, 0);
    applyStimulus(8, -1);

    $display("%0d/%0d checks passed", checksPassed, checksRun);
    $finish;
  end
endmodule
